// File: rtl/vecmac_acc_collector.sv
// Long-K dot-product collector: accumulates cfg_len_i multiplier beats per result, buffers the
// results in a show-ahead FIFO and issues feeder credit. Optional macro: VECMAC_ACC_SAT_EN.
module vecmac_acc_collector #(
    parameter int unsigned SUM_W      = 19,
    parameter int unsigned ACC_W      = 32,
    parameter int unsigned LEN_W      = 8,
    parameter int unsigned FIFO_DEPTH = 8
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [LEN_W-1:0] cfg_len_i,
    input  logic             issue_req_i,
    output logic             issue_ok_o,
    input  logic             flush_i,
    input  logic             in_valid_i,
    input  logic [SUM_W-1:0] in_sum_i,
    output logic             out_valid_o,
    input  logic             out_ready_i,
    output logic [ACC_W-1:0] out_data_o,
    output logic             err_ovr_o
);

    localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;
    localparam int unsigned INF_W = PTR_W + 2;

    // Group accumulation state
    logic [ACC_W-1:0] acc_q, acc_d;
    logic [LEN_W-1:0] beat_cnt_q, beat_cnt_d;
    logic [LEN_W-1:0] len_q, len_d;

    // Credit and FIFO state
    logic [INF_W-1:0] inflight_q, inflight_d;
    logic [PTR_W-1:0] wptr_q, wptr_d;
    logic [PTR_W-1:0] rptr_q, rptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             err_ovr_q, err_ovr_d;
    logic [ACC_W-1:0] mem_q [FIFO_DEPTH];

    logic [LEN_W-1:0] cfg_eff;
    logic [LEN_W-1:0] len_eff;
    logic [ACC_W-1:0] acc_sum;
    logic             push;
    logic [ACC_W-1:0] push_data;
    logic             pop;
    logic             full;
    logic             push_ok;

    assign cfg_eff = (cfg_len_i == '0) ? LEN_W'(1) : cfg_len_i;
    // A group starting this cycle must close against the freshly sampled length.
    assign len_eff = (beat_cnt_q == '0) ? cfg_eff : len_q;

`ifdef VECMAC_ACC_SAT_EN
    logic [ACC_W:0] sum_wide;

    assign sum_wide = {1'b0, acc_q} + {{(ACC_W + 1 - SUM_W){1'b0}}, in_sum_i};
    assign acc_sum  = sum_wide[ACC_W] ? {ACC_W{1'b1}} : sum_wide[ACC_W-1:0];
`else
    assign acc_sum = acc_q + {{(ACC_W - SUM_W){1'b0}}, in_sum_i};
`endif

    always_comb begin
        acc_d      = acc_q;
        beat_cnt_d = beat_cnt_q;
        len_d      = len_q;
        push       = 1'b0;
        push_data  = in_valid_i ? acc_sum : acc_q;

        if (beat_cnt_q == '0) begin
            len_d = cfg_eff;
        end

        if (in_valid_i && (beat_cnt_q == len_eff - LEN_W'(1))) begin
            push = 1'b1;
        end else if (flush_i && (in_valid_i || (beat_cnt_q != '0))) begin
            push = 1'b1;
        end

        if (push) begin
            acc_d      = '0;
            beat_cnt_d = '0;
        end else if (in_valid_i) begin
            acc_d      = acc_sum;
            beat_cnt_d = beat_cnt_q + LEN_W'(1);
        end
    end

    assign out_valid_o = (count_q != '0);
    assign out_data_o  = out_valid_o ? mem_q[rptr_q] : '0;
    assign pop         = out_valid_o && out_ready_i;
    assign full        = (count_q == CNT_W'(FIFO_DEPTH));
    // A pop in the same cycle frees the slot, so a full FIFO can still accept.
    assign push_ok     = push && (!full || pop);

    always_comb begin
        wptr_d    = wptr_q;
        rptr_d    = rptr_q;
        count_d   = count_q;
        err_ovr_d = err_ovr_q;

        if (push_ok) begin
            wptr_d = wptr_q + PTR_W'(1);
        end
        if (pop) begin
            rptr_d = rptr_q + PTR_W'(1);
        end
        if (push_ok && !pop) begin
            count_d = count_q + CNT_W'(1);
        end else if (pop && !push_ok) begin
            count_d = count_q - CNT_W'(1);
        end
        if (push && full && !pop) begin
            err_ovr_d = 1'b1;
        end
    end

    always_comb begin
        inflight_d = inflight_q;
        case ({issue_req_i, in_valid_i})
            2'b10: begin
                if (inflight_q != '1) begin
                    inflight_d = inflight_q + INF_W'(1);
                end
            end
            2'b01: begin
                if (inflight_q != '0) begin
                    inflight_d = inflight_q - INF_W'(1);
                end
            end
            default: begin
                inflight_d = inflight_q;
            end
        endcase
    end

    // Conservative: every beat in flight may close a group and need a slot.
    assign issue_ok_o = (({1'b0, inflight_q}) + (INF_W + 1)'(count_q)) < (INF_W + 1)'(FIFO_DEPTH);
    assign err_ovr_o  = err_ovr_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            acc_q      <= '0;
            beat_cnt_q <= '0;
            len_q      <= LEN_W'(1);
            inflight_q <= '0;
            wptr_q     <= '0;
            rptr_q     <= '0;
            count_q    <= '0;
            err_ovr_q  <= 1'b0;
        end else begin
            acc_q      <= acc_d;
            beat_cnt_q <= beat_cnt_d;
            len_q      <= len_d;
            inflight_q <= inflight_d;
            wptr_q     <= wptr_d;
            rptr_q     <= rptr_d;
            count_q    <= count_d;
            err_ovr_q  <= err_ovr_d;
        end
    end

    // Storage needs no reset: out_data_o is gated by the entry count.
    always_ff @(posedge clk_i) begin
        if (push_ok) begin
            mem_q[wptr_q] <= push_data;
        end
    end

endmodule

// File: tb/tb_vecmac_acc_collector.sv
// Self-checking bench for vecmac_acc_collector: directed steps plus randomized traffic against a
// queue-based reference model; a second ACC_W=20 instance covers the narrow-accumulator case.
module tb_vecmac_acc_collector;

    localparam int DEPTH = 8;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [7:0]  cfg_len = 8'd1;
    logic        issue_req = 1'b0;
    logic        flush = 1'b0;
    logic        in_valid = 1'b0;
    logic [18:0] in_sum = '0;
    logic        out_ready = 1'b0;

    logic        issue_ok, out_valid, err_ovr;
    logic [31:0] out_data;
    logic        issue_ok20, out_valid20, err_ovr20;
    logic [19:0] out_data20;

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model state
    int unsigned grp[$];
    int unsigned glen;
    longint unsigned exp_q[$];
    bit m_err;
    int m_inf;

    always #5 clk = ~clk;

    vecmac_acc_collector #(.SUM_W(19), .ACC_W(32), .LEN_W(8), .FIFO_DEPTH(DEPTH)) dut (
        .clk_i(clk), .rst_i(rst), .cfg_len_i(cfg_len), .issue_req_i(issue_req),
        .issue_ok_o(issue_ok), .flush_i(flush), .in_valid_i(in_valid), .in_sum_i(in_sum),
        .out_valid_o(out_valid), .out_ready_i(out_ready), .out_data_o(out_data),
        .err_ovr_o(err_ovr)
    );

    vecmac_acc_collector #(.SUM_W(19), .ACC_W(20), .LEN_W(8), .FIFO_DEPTH(DEPTH)) dut20 (
        .clk_i(clk), .rst_i(rst), .cfg_len_i(cfg_len), .issue_req_i(issue_req),
        .issue_ok_o(issue_ok20), .flush_i(flush), .in_valid_i(in_valid), .in_sum_i(in_sum),
        .out_valid_o(out_valid20), .out_ready_i(out_ready), .out_data_o(out_data20),
        .err_ovr_o(err_ovr20)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    endtask

    function automatic longint unsigned fold(input int unsigned beats[$], input int w);
        longint unsigned total = 0;
        longint unsigned lim = 64'd1 << w;
        foreach (beats[i]) total += beats[i];
`ifdef VECMAC_ACC_SAT_EN
        return (total >= lim) ? lim - 1 : total;
`else
        return total % lim;
`endif
    endfunction

    function automatic bit model_ok();
        return (exp_q.size() + m_inf) < DEPTH;
    endfunction

    task automatic check_outputs();
        chk("out_valid", out_valid, exp_q.size() != 0);
        chk("out_data", out_data, (exp_q.size() != 0) ? exp_q[0] : 64'd0);
        chk("issue_ok", issue_ok, model_ok());
        chk("err_ovr", err_ovr, m_err);
    endtask

    task automatic do_reset();
        rst = 1'b1; in_valid = 1'b0; flush = 1'b0; issue_req = 1'b0; out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        grp.delete(); exp_q.delete(); m_err = 1'b0; m_inf = 0; glen = 1;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_data", out_data, 0);
        chk("rst_err_ovr", err_ovr, 0);
        chk("rst_issue_ok", issue_ok, 1);
    endtask

    // One clock: drive inputs, advance the model, then sample just after the edge.
    task automatic cycle(input bit iv, input int unsigned s, input bit fl, input bit rdy,
                         input bit ireq);
        bit pop, push, full_pre;
        longint unsigned res;
        in_valid = iv; in_sum = s[18:0]; flush = fl; out_ready = rdy; issue_req = ireq;
        pop = rdy && (exp_q.size() != 0);
        full_pre = (exp_q.size() == DEPTH);
        push = 1'b0;
        res = 0;
        if (grp.size() == 0) glen = (cfg_len == 0) ? 1 : cfg_len;
        if (iv) grp.push_back(s);
        if ((iv && grp.size() == glen) || (fl && grp.size() != 0)) begin
            push = 1'b1;
            res = fold(grp, 32);
            grp.delete();
        end
        if (pop) void'(exp_q.pop_front());
        if (push) begin
            if (full_pre && !pop) m_err = 1'b1;
            else exp_q.push_back(res);
        end
        if (ireq && !iv) m_inf++;
        else if (!ireq && iv && m_inf > 0) m_inf--;
        @(posedge clk);
        #1;
        check_outputs();
    endtask

    initial begin
        longint unsigned held[$];
        int unsigned r;

        do_reset();

        // 1: single-beat groups, each result visible one cycle after its beat
        cfg_len = 8'd1;
        cycle(1, 0, 0, 1, 0);
        chk("t1_beat0", out_data, 0);
        cycle(1, 520200, 0, 1, 0);
        chk("t1_beat1", out_data, 520200);
        cycle(1, 1, 0, 1, 0);
        chk("t1_beat2", out_data, 1);
        cycle(0, 0, 0, 1, 0);

        // 2: four-beat group, cfg change mid-group ignored
        cfg_len = 8'd4;
        cycle(1, 100, 0, 1, 0);
        cfg_len = 8'd2;
        cycle(1, 200, 0, 1, 0);
        cycle(1, 300, 0, 0, 0);
        chk("t2_open", out_valid, 0);
        cycle(1, 400, 0, 1, 0);
        chk("t2_sum", out_data, 1000);
        cycle(0, 0, 0, 1, 0);

        // 3: partial group closed by flush, then a fresh group
        cfg_len = 8'd8;
        repeat (3) cycle(1, 10, 0, 1, 0);
        cycle(0, 0, 1, 1, 0);
        chk("t3_flush", out_data, 30);
        cycle(0, 0, 1, 1, 0);
        chk("t3_idle_flush", out_valid, 0);
        cfg_len = 8'd2;
        cycle(1, 5, 0, 1, 0);
        cycle(1, 6, 0, 1, 0);
        chk("t3_restart", out_data, 11);
        cycle(0, 0, 0, 1, 0);

        // 4/5: credit exhaustion, full FIFO, overflow drop and in-order drain
        do_reset();
        cfg_len = 8'd1;
        repeat (DEPTH) cycle(0, 0, 0, 0, 1);
        chk("t4_credit", issue_ok, 0);
        for (int i = 0; i < DEPTH; i++) begin
            r = $urandom_range(0, 524287);
            held.push_back(r);
            cycle(1, r, 0, 0, 0);
        end
        chk("t4_full_valid", out_valid, 1);
        cycle(1, 12345, 0, 0, 0);
        chk("t5_err", err_ovr, 1);
        for (int i = 0; i < DEPTH; i++) begin
            chk("t5_drain", out_data, held[i]);
            cycle(0, 0, 0, 1, 0);
        end
        chk("t5_empty", out_valid, 0);

        // Randomized traffic with random lengths, flushes and backpressure
        for (int i = 0; i < 600; i++) begin
            cfg_len = 8'($urandom_range(0, 5));
            cycle($urandom_range(0, 1) == 1, $urandom_range(0, 524287),
                  $urandom_range(0, 9) == 0, $urandom_range(0, 2) != 0,
                  model_ok() && ($urandom_range(0, 1) == 1));
        end

        // Reset mid-group discards partial state
        cfg_len = 8'd4;
        cycle(1, 77, 0, 0, 0);
        do_reset();

        // 6: narrow accumulator overflow behaviour
        cfg_len = 8'd4;
        repeat (4) cycle(1, 520200, 0, 1, 0);
        chk("t6_wide", out_data, 2080800);
        chk("t6_valid20", out_valid20, 1);
`ifdef VECMAC_ACC_SAT_EN
        chk("t6_narrow", out_data20, 1048575);
`else
        chk("t6_narrow", out_data20, 1032224);
`endif
        chk("t6_err20", err_ovr20, 0);
        chk("t6_ok20", issue_ok20, model_ok());
        cycle(0, 0, 0, 1, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
